// File: rtl/fifo_axis_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_axis_pkg                                                              |
// | Shared types for the FIFO-to-AXI4-Stream read-side stage.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fifo_axis_pkg;

  localparam int unsigned c_slot_count = 2;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] state_to_occ(input state_t s);
    case (s)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'(c_slot_count);
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_axis_out_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_axis_out_stage                                                        |
// | Pops a FWFT sync FIFO into a 2-entry registered skid buffer and presents  |
// | it as an AXI4-Stream master. Optional tlast: FIFO_AXIS_OUT_TLAST_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_axis_out_stage
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PKT_LEN        = 16,
  parameter int BEAT_CNT_WIDTH = $clog2(PKT_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [1:0]            occupancy
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_load_head_fifo;
  logic                  w_load_head_skid;
  logic                  w_load_skid;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [DATA_WIDTH-1:0] r_skid_data;

  // Pop depends only on registered state, keeping tready off the rd_en path.
  assign w_pop    = !fifo_empty && (r_state != S_TWO);
  assign w_accept = (r_state != S_EMPTY) && m_axis_tready;

  always_comb begin
    w_next_state     = r_state;
    w_load_head_fifo = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_pop) begin
          w_next_state     = S_ONE;
          w_load_head_fifo = 1'b1;
        end
      end
      S_ONE: begin
        if (w_pop && w_accept) begin
          w_load_head_fifo = 1'b1;
        end else if (w_pop) begin
          w_next_state = S_TWO;
          w_load_skid  = 1'b1;
        end else if (w_accept) begin
          w_next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_accept) begin
          w_next_state     = S_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: begin
        w_next_state = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_head_fifo) begin
        r_head_data <= fifo_rd_data;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= fifo_rd_data;
      end
    end
  end

`ifdef FIFO_AXIS_OUT_TLAST_EN
  localparam logic [BEAT_CNT_WIDTH-1:0] c_last_beat = BEAT_CNT_WIDTH'(PKT_LEN - 1);

  logic [BEAT_CNT_WIDTH-1:0] r_pop_cnt;
  logic                      w_pop_last;
  logic                      r_head_last;
  logic                      r_skid_last;

  // Counting pops equals counting accepts because beat order is preserved.
  assign w_pop_last = (r_pop_cnt == c_last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_cnt   <= '0;
      r_head_last <= 1'b0;
      r_skid_last <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pop_cnt <= w_pop_last ? '0 : r_pop_cnt + BEAT_CNT_WIDTH'(1);
      end
      if (w_load_head_fifo) begin
        r_head_last <= w_pop_last;
      end else if (w_load_head_skid) begin
        r_head_last <= r_skid_last;
      end
      if (w_load_skid) begin
        r_skid_last <= w_pop_last;
      end
    end
  end

  assign m_axis_tlast = r_head_last;
`else
  logic [BEAT_CNT_WIDTH-1:0] w_unused_cnt;
  assign w_unused_cnt = BEAT_CNT_WIDTH'(PKT_LEN - 1);
  assign m_axis_tlast = 1'b0;
`endif

  assign fifo_rd_en    = w_pop;
  assign m_axis_tvalid = (r_state != S_EMPTY);
  assign m_axis_tdata  = r_head_data;
  assign occupancy     = state_to_occ(r_state);

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_out_stage.sv
`default_nettype none
// Directed bench for fifo_axis_out_stage with a behavioural FWFT FIFO in front.
module tb_fifo_axis_out_stage;

  localparam int c_pkt_len = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic [1:0] occupancy;

  int errors = 0;
  int checks = 0;
  int rd_en_count = 0;
  logic [7:0] q[$];
  bit pop_seen = 1'b0;

  fifo_axis_out_stage #(
    .DATA_WIDTH(8),
    .PKT_LEN   (c_pkt_len)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pop_seen = fifo_rd_en && rst_n;
    if (pop_seen) rd_en_count++;
  end

  // FIFO model: pointer advance is applied half a cycle after the popping edge.
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else if (pop_seen && q.size() > 0) void'(q.pop_front());
    pop_seen     = 1'b0;
    fifo_empty   = (q.size() == 0);
    fifo_rd_data = (q.size() > 0) ? q[0] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    rst_n = 1'b1;
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_release_tvalid: got %b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    int base;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    m_axis_tready = 1'b1;
    base = rd_en_count;
    for (int i = 0; i < 3; i++) q.push_back(exp_d[i]);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_pre_tvalid: got %b expected 0", m_axis_tvalid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_tvalid[%0d]: got %b expected 1", i, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== exp_d[i]) begin errors++; $display("FAIL b2b_tdata[%0d]: got %h expected %h", i, m_axis_tdata, exp_d[i]); end
    end
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_end_occ: got %0d expected 0", occupancy); end
    checks++; if (rd_en_count - base !== 3) begin errors++; $display("FAIL b2b_rd_en_pulses: got %0d expected 3", rd_en_count - base); end
  endtask

  task automatic test_backpressure();
    int n;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA0) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=a0", i, m_axis_tvalid, m_axis_tdata); end
      if (i >= 1) begin
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ[%0d]: got %0d expected 2", i, occupancy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en[%0d]: got %b expected 0", i, fifo_rd_en); end
      end
    end
    m_axis_tready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (m_axis_tvalid) begin
        checks++; if (m_axis_tdata !== 8'hA0 + 8'(n)) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", n, m_axis_tdata, 8'hA0 + 8'(n)); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", n); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bp_end_occ: got %0d expected 0", occupancy); end
  endtask

  task automatic test_random();
    int pushed = 0;
    int rcv = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    for (int c = 0; c < 6000 && rcv < 1000; c++) begin
      if (pushed < 1000 && q.size() < 8) begin
        q.push_back(8'(pushed));
        pushed++;
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d) begin errors++; $display("FAIL rnd_stable: got v=%b d=%h expected v=1 d=%h", m_axis_tvalid, m_axis_tdata, prev_d); end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== 8'(rcv)) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", rcv, m_axis_tdata, 8'(rcv)); end
        rcv++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      tick();
    end
    checks++; if (rcv !== 1000) begin errors++; $display("FAIL rnd_count: got %0d expected 1000", rcv); end
  endtask

  task automatic test_reset_midflight();
    int n;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(8'hC0 + 8'(i));
    repeat (3) tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rst_mid_setup_occ: got %0d expected 2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_mid_tdata: got %h expected 00", m_axis_tdata); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d expected 0", occupancy); end
    repeat (2) tick();
    rst_n = 1'b1;
    q.push_back(8'hD0);
    q.push_back(8'hD1);
    m_axis_tready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== 8'hD0 + 8'(n)) begin errors++; $display("FAIL rst_mid_beat[%0d]: got %h expected %h", n, m_axis_tdata, 8'hD0 + 8'(n)); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL rst_mid_count: got %0d expected 2", n); end
  endtask

  task automatic test_tlast();
    int n;
    logic exp_last;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) q.push_back(8'hE0 + 8'(i));
    n = 0;
    for (int c = 0; c < 200 && n < 12; c++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      if (m_axis_tvalid && m_axis_tready) begin
`ifdef FIFO_AXIS_OUT_TLAST_EN
        exp_last = ((n % c_pkt_len) == c_pkt_len - 1);
`else
        exp_last = 1'b0;
`endif
        checks++; if (m_axis_tlast !== exp_last) begin errors++; $display("FAIL tlast[%0d]: got %b expected %b", n, m_axis_tlast, exp_last); end
        checks++; if (m_axis_tdata !== 8'hE0 + 8'(n)) begin errors++; $display("FAIL tlast_data[%0d]: got %h expected %h", n, m_axis_tdata, 8'hE0 + 8'(n)); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 12) begin errors++; $display("FAIL tlast_count: got %0d expected 12", n); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = i[0];
      tick();
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en[%0d]: got %b expected 0", i, fifo_rd_en); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid[%0d]: got %b expected 0", i, m_axis_tvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_tlast();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fifo_axis_out_stage.md
Name: fifo_axis_out_stage

Overview:
- Downstream read-side stage for the shallow distributed-RAM sync FIFO.
- Pops the FIFO through its `rd_en`/`empty`/`rd_data` interface. `rd_data` is combinational from the read pointer, so head data is valid whenever `empty` = 0.
- Presents the data as AXI4-Stream master (valid/ready) from a 2-entry registered skid buffer.
- No combinational path from `m_axis_tready` to `fifo_rd_en`.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and tdata.
- PKT_LEN, 16, beats per packet for tlast generation (used only with macro; >= 1).
- BEAT_CNT_WIDTH, $clog2(PKT_LEN)+1, width of beat counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO head data, valid when fifo_empty=0.
- fifo_rd_en  output  1  pop request to FIFO.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tlast  output  1  end of packet (tied 0 without macro).
- occupancy  output  2  entries held in stage (0..2).

Behaviour:
- Reset (async assert, sync release):
  - State S_EMPTY, both slots cleared to 0, beat counter 0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, occupancy=0.
- Storage: head slot drives m_axis_tdata/tlast directly; skid slot holds the second entry.
- State machine, by registered occupancy:
  - S_EMPTY: pop → S_ONE.
  - S_ONE: pop & !accept → S_TWO; !pop & accept → S_EMPTY; else stay.
  - S_TWO: accept → S_ONE; no pop possible.
- pop = fifo_rd_en; accept = m_axis_tvalid & m_axis_tready.
- fifo_rd_en = !fifo_empty & (state != S_TWO). This is a function of registered state and fifo_empty only.
  - fifo_empty from an in-reset FIFO is 1, so fifo_rd_en=0 during reset.
- Data capture on pop, same edge as the FIFO pointer advance:
  - S_EMPTY: into head.
  - S_ONE & accept: into head.
  - S_ONE & !accept: into skid.
- On accept in S_TWO, skid moves to head.
- Order strictly preserved.
- m_axis_tvalid = (state != S_EMPTY), registered.
- While tvalid=1 and tready=0, tdata/tlast are held stable.
- Latency: fifo_empty falls in cycle N → m_axis_tvalid=1 in N+1.
- Throughput: sustained 1 beat/cycle with tready held high.
- Recovery from S_TWO costs one cycle with no pop.
- Backpressure: tready low for 2+ cycles fills S_TWO, then fifo_rd_en=0. No data is lost.
- Simultaneous pop+accept in S_ONE: occupancy stays 1, head replaced.
- tready with tvalid=0: ignored.
- Reset mid-transfer: held data discarded, outputs go to reset values immediately.

Optional Feature:
- Macro: FIFO_AXIS_OUT_TLAST_EN.
- Defined:
  - Beat counter increments per accept.
  - tlast=1 on the beat whose count is PKT_LEN-1; counter then wraps to 0.
  - tlast is tracked per slot: computed at pop time from a pop-side counter and stored with the data.
  - PKT_LEN=1 gives tlast on every beat.
- Undefined:
  - No counter or tlast flops.
  - m_axis_tlast tied 0.

Decomposition:
- Package fifo_axis_pkg:
  - State enum typedef (S_EMPTY, S_ONE, S_TWO; 2-bit encoding).
  - Localparam for slot count = 2.
- No sub-module needed; the beat counter stays inline under the macro.
- Top-level integration instantiates shallow_fifo_sync plus this stage.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33 and tready=1:
  - tvalid rises 1 cycle after empty falls.
  - Beats 0x11,0x22,0x33 on consecutive cycles.
  - fifo_rd_en pulses 3 cycles; occupancy returns to 0.
- FIFO holding 8 entries, tready=0 for 5 cycles, then 1:
  - occupancy reaches 2, fifo_rd_en=0 while in S_TWO.
  - tdata stable at first value.
  - All 8 values delivered in order, none dropped or duplicated.
- Random tready (50%) with continuous FIFO writes of an incrementing byte 0x00..0xFF, 1000 beats:
  - Output sequence matches input exactly.
  - tdata never changes while tvalid & !tready.
- Assert rst_n low while occupancy=2 and tvalid=1:
  - tvalid, tdata, occupancy go 0 asynchronously.
  - After release, the first beat is the FIFO's new head.
- FIFO_AXIS_OUT_TLAST_EN, PKT_LEN=4, 12 beats with random stalls:
  - tlast=1 exactly on beats 4, 8, 12.
- fifo_empty=1 throughout with tready toggling:
  - fifo_rd_en=0 and tvalid=0 every cycle.
